cic3_out_fifo: RTL and testbench

- Downstream consumer of the 25-bit CIC3 decimator output.
- Runs on the fast modulator clock only.
- Detects each decimated-sample update by sampling the divided clock as data.
- Discards the CIC settling samples, rounds and saturates each word to OUT_WIDTH, and buffers it in a small show-ahead FIFO with a valid/ready readout interface and a sticky overflow flag.

---
 rtl/cic3_out_pkg.sv | 33 +++
 rtl/sync_fifo_fwft.sv | 55 +++++
 rtl/cic3_out_fifo.sv | 85 ++++++++
 tb/tb_cic3_out_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cic3_out_pkg.sv
// cic3_out_pkg: shared widths, defaults and the output formatting helper for
// the CIC3 output FIFO.
//   IN_WIDTH    CIC output word width (unsigned, 0..2^24)
//   OUT_WIDTH   formatted sample width
//   SHIFT       right shift applied after rounding
//   DEF_DEPTH   default FIFO depth
//   DEF_SETTLE  default number of settling samples discarded
package cic3_out_pkg;

  localparam int IN_WIDTH   = 25;
  localparam int OUT_WIDTH  = 16;
  localparam int SHIFT      = IN_WIDTH - OUT_WIDTH;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_SETTLE = 3;

  typedef logic [OUT_WIDTH-1:0] sample_t;

  // Half an output LSB, added before truncation for round-half-up.
  localparam logic [IN_WIDTH:0] RND = (IN_WIDTH+1)'(1) << (SHIFT-1);
  localparam logic [IN_WIDTH-SHIFT:0] SAT_MAX = (IN_WIDTH-SHIFT+1)'((1 << OUT_WIDTH) - 1);

  // Round, shift and clamp one CIC word. The sum carries one extra bit so a
  // full-scale input rounds up into the saturation range instead of wrapping.
  function automatic sample_t round_sat(input logic [IN_WIDTH-1:0] w);
    logic [IN_WIDTH:0]       sum;
    logic [IN_WIDTH-SHIFT:0] q;
    sum = {1'b0, w} + RND;
    q   = sum[IN_WIDTH:SHIFT];
    if (q > SAT_MAX) return '1;
    else             return q[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: generic show-ahead FIFO.
//   clk, reset_n  clock, async active-low reset
//   push, wdata   write request/data; ignored (and flagged on drop) when full
//                 unless a pop happens in the same cycle
//   pop           read request; ignored when empty
//   rdata         head entry, valid whenever empty=0
//   full, empty   status
//   level         occupancy (0..DEPTH)
//   drop          push rejected this cycle (combinational)
module sync_fifo_fwft #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cic3_out_fifo.sv
// cic3_out_fifo: captures decimated CIC3 words in the fast clock domain,
// drops the filter settling samples, rounds/saturates to OUT_WIDTH and
// buffers them in a show-ahead FIFO.
//   clk, reset_n  modulator clock, async active-low reset
//   en            capture enable; low clears the settle counter
//   cic_out       CIC output word, stable at the capture strobe
//   divided_clk   decimated clock, sampled as data; falling edge = new word
//   m_data/m_valid/m_ready  show-ahead readout handshake
//   level         FIFO occupancy
//   ovf, ovf_clr  sticky overflow flag and its synchronous clear
module cic3_out_fifo
  import cic3_out_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int SETTLE_SAMPLES = DEF_SETTLE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [IN_WIDTH-1:0]    cic_out,
  input  logic                   divided_clk,
  output sample_t                m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  input  logic                   ovf_clr
);
  localparam int CW = $clog2(SETTLE_SAMPLES + 1);

  logic          div_q;
  logic          strobe, accept;
  logic [CW-1:0] settle_cnt;
  sample_t       fmt;
  logic          fmt_vld;
  logic          full, empty, drop;

  // divided_clk falls on a clk negedge, so div_q still holds the old high
  // level at the following posedge while the live input already reads low.
  assign strobe = div_q & ~divided_clk & en;
  assign accept = strobe && (settle_cnt == CW'(SETTLE_SAMPLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= 1'b0;
      settle_cnt <= '0;
      fmt        <= '0;
      fmt_vld    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      div_q <= divided_clk;

      // Saturating count of strobes; dropping en forces a fresh settle.
      if (!en)                                           settle_cnt <= '0;
      else if (strobe && settle_cnt != CW'(SETTLE_SAMPLES)) settle_cnt <= settle_cnt + 1'b1;

      // One-cycle format stage; an in-flight word still lands if en falls.
      fmt_vld <= accept;
      if (accept) fmt <= round_sat(cic_out);

      // A drop in the same cycle as a clear wins so no overflow goes unseen.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  sync_fifo_fwft #(
    .W     (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fmt_vld),
    .wdata   (fmt),
    .pop     (m_ready),
    .rdata   (m_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .drop    (drop)
  );

  assign m_valid = ~empty;

endmodule

// File: tb/tb_cic3_out_fifo.sv
module tb_cic3_out_fifo;

  localparam int HALF  = 128;   // divided_clk half period in clk cycles
  localparam int DEPTH = 8;
  localparam int SETTLE = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [24:0] cic_out;
  logic        divided_clk;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  level;
  logic        ovf;
  logic        ovf_clr;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  int          settle;
  logic        exp_ovf;

  cic3_out_fifo dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .cic_out     (cic_out),
    .divided_clk (divided_clk),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .level       (level),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  // Round-half-up, shift by 9, clamp to 16 bits, in plain integer arithmetic.
  function automatic logic [15:0] ref_fmt(input logic [24:0] w);
    longint v;
    v = (longint'(w) + 256) / 512;
    if (v > 65535) v = 65535;
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model reaction to one falling edge of divided_clk carrying word w.
  // Returns 1 when the word is to be pushed into the FIFO.
  function automatic bit model_strobe();
    if (!en) return 0;
    if (settle < SETTLE) begin
      settle++;
      return 0;
    end
    return 1;
  endfunction

  // One divided_clk period. mode 0: plain; 1: check push latency into an
  // empty FIFO; 2: pop the head in the exact cycle the new word is pushed.
  task automatic div_cycle(input logic [24:0] w, input int mode);
    bit push;
    @(negedge clk);
    cic_out     = w;
    divided_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    divided_clk = 1'b0;
    push = model_strobe();
    if (mode == 1) begin
      @(posedge clk); #1;
      chk("lat_n_valid", 32'(m_valid), 0);
      @(posedge clk); #1;
      chk("lat_n1_valid", 32'(m_valid), 1);
      chk("lat_n1_data", 32'(m_data), 32'(ref_fmt(w)));
    end else if (mode == 2) begin
      @(negedge clk);
      chk("coinc_head", 32'(m_data), 32'(exp_q[0]));
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(ref_fmt(w));
      else                      exp_ovf = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    chk("level", 32'(level), exp_q.size());
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    chk("valid", 32'(m_valid), 32'(exp_q.size() != 0));
  endtask

  task automatic pop_one();
    @(negedge clk);
    chk("pop_valid", 32'(m_valid), 1);
    if (exp_q.size() > 0) begin
      chk("pop_data", 32'(m_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; cic_out = 25'h1000000; divided_clk = 1'b0;
    m_ready = 1'b0; ovf_clr = 1'b0;
    settle = 0; exp_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_data", 32'(m_data), 0);
    reset_n = 1'b1;

    // Settling: three discarded words, the fourth lands two edges later.
    repeat (SETTLE) div_cycle(25'h1000000, 0);
    div_cycle(25'h1000000, 1);
    pop_one();

    // Rounding boundaries and saturation.
    div_cycle(25'h00000FF, 0);
    div_cycle(25'h0000100, 0);
    div_cycle(25'h1FFFFFF, 0);
    repeat (3) pop_one();

    // Overflow: ten words into eight slots, then clear the flag.
    repeat (10) div_cycle(25'($urandom), 0);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);
    // Full FIFO with a pop in the push cycle: accepted, no overflow.
    div_cycle(25'($urandom), 2);
    repeat (DEPTH) pop_one();
    chk("drained_valid", 32'(m_valid), 0);

    // en low for five periods, then re-settle.
    @(negedge clk); en = 1'b0; settle = 0;
    repeat (5) div_cycle(25'($urandom), 0);
    @(negedge clk); en = 1'b1;
    repeat (SETTLE + 1) div_cycle(25'($urandom), 0);
    pop_one();

    // Asynchronous reset with five words buffered and ovf set.
    repeat (10) div_cycle(25'($urandom), 0);
    repeat (3) pop_one();
    chk("pre_rst_level", 32'(level), 5);
    @(negedge clk); reset_n = 1'b0; #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_valid", 32'(m_valid), 0);
    chk("arst_ovf", 32'(ovf), 0);
    exp_q.delete(); exp_ovf = 1'b0; settle = 0;
    @(negedge clk); reset_n = 1'b1;
    repeat (SETTLE + 1) div_cycle(25'($urandom), 0);
    pop_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
